// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared definitions for the branch predictor: 2-bit counter
//               encodings, PC index/tag slicing helpers and the BTB entry
//               layout for the default configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Direction counter encodings for the 2-bit configuration
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // BTB entry layout for the default configuration (XLEN=32, TAG_W=8, CNT_W=2)
    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic [31:0] target;
        logic [1:0]  cnt;
    } bp_entry_t;

    // Table index: pc[idx_w+1:2], returned zero-extended
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Stored tag: pc[idx_w+tag_w+1:idx_w+2], returned zero-extended
    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Combinational next-state function of a saturating direction
//               counter. force_max wins over the taken/not-taken step.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] i_cur,
    input  logic             i_taken,
    input  logic             i_force_max,
    output logic [CNT_W-1:0] o_nxt
);

    localparam logic [CNT_W-1:0] c_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_min  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] c_step = CNT_W'(1);

    // Saturating increment/decrement, clamped at both ends
    always_comb begin
        o_nxt = i_cur;
        if (i_force_max) begin
            o_nxt = c_max;
        end else if (i_taken) begin
            if (i_cur != c_max) begin
                o_nxt = i_cur + c_step;
            end
        end else if (i_cur != c_min) begin
            o_nxt = i_cur - c_step;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with saturating-counter direction
//               prediction. Combinational lookup in IF, update and
//               mispredict detection from EX resolution.
//               Optional build macro BP_GSHARE_EN: moves the counters into a
//               pattern table indexed by (pc index XOR global history).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_IF,
    output logic            pred_hit_IF,
    output logic            pred_taken_IF,
    output logic [XLEN-1:0] pred_target_IF,
    input  logic            upd_valid_EX,
    input  logic            upd_cond_EX,
    input  logic [XLEN-1:0] upd_pc_EX,
    input  logic            upd_taken_EX,
    input  logic [XLEN-1:0] upd_target_EX,
    input  logic            upd_pred_taken_EX,
    input  logic [XLEN-1:0] upd_pred_target_EX,
    output logic            mispredict_EX,
    output logic [XLEN-1:0] redirect_pc_EX
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Reset / allocation base value: weakly-not-taken
    localparam logic [CNT_W-1:0] c_cnt_wnt = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [XLEN-1:0]  c_pc_step = XLEN'(4);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
`ifndef BP_GSHARE_EN
        logic [CNT_W-1:0] cnt;
`endif
    } entry_t;

    entry_t r_btb [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [TAG_W-1:0] w_upd_tag;
    entry_t           w_lk_entry;
    entry_t           w_upd_entry;
    entry_t           w_btb_nxt;
    logic             w_lk_hit;
    logic             w_upd_hit;
    logic             w_btb_we;
    logic             w_force_max;
    logic [CNT_W-1:0] w_lk_cnt;
    logic [CNT_W-1:0] w_upd_cnt;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_nxt;

    // ---------------------------------------------------------------- lookup
    assign w_lk_idx   = IDX_W'(bp_index(64'(pc_IF), IDX_W));
    assign w_lk_tag   = TAG_W'(bp_tag(64'(pc_IF), IDX_W, TAG_W));
    assign w_lk_entry = r_btb[w_lk_idx];
    assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    assign pred_hit_IF    = w_lk_hit;
    assign pred_taken_IF  = w_lk_hit && w_lk_cnt[CNT_W-1];
    assign pred_target_IF = pred_taken_IF ? w_lk_entry.target : pc_IF + c_pc_step;

    // ------------------------------------------------------------ resolution
    // Gated by reset so no flush is requested while the core is held in reset
    assign mispredict_EX  = rst && upd_valid_EX &&
                            ((upd_pred_taken_EX != upd_taken_EX) ||
                             (upd_taken_EX && (upd_pred_target_EX != upd_target_EX)));
    assign redirect_pc_EX = upd_taken_EX ? upd_target_EX : upd_pc_EX + c_pc_step;

    // ---------------------------------------------------------------- update
    assign w_upd_idx   = IDX_W'(bp_index(64'(upd_pc_EX), IDX_W));
    assign w_upd_tag   = TAG_W'(bp_tag(64'(upd_pc_EX), IDX_W, TAG_W));
    assign w_upd_entry = r_btb[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    // A miss starts from weakly-not-taken so one taken step yields weakly-taken,
    // and force_max covers the jump cases; the same counter serves both paths
    assign w_cnt_cur   = w_upd_hit ? w_upd_cnt : c_cnt_wnt;
    assign w_force_max = !upd_cond_EX;

    bp_sat_counter #(
        .CNT_W       (CNT_W)
    ) u_sat_counter (
        .i_cur       (w_cnt_cur),
        .i_taken     (upd_taken_EX),
        .i_force_max (w_force_max),
        .o_nxt       (w_cnt_nxt)
    );

    // Next BTB entry: refresh on a hit, allocate on a taken miss
    always_comb begin
        w_btb_we  = 1'b0;
        w_btb_nxt = w_upd_entry;
        if (upd_valid_EX) begin
            if (w_upd_hit) begin
                w_btb_we = 1'b1;
                if (!upd_cond_EX || upd_taken_EX) begin
                    w_btb_nxt.target = upd_target_EX;
                end
            end else if (upd_taken_EX) begin
                w_btb_we         = 1'b1;
                w_btb_nxt.valid  = 1'b1;
                w_btb_nxt.tag    = w_upd_tag;
                w_btb_nxt.target = upd_target_EX;
            end
        end
`ifndef BP_GSHARE_EN
        w_btb_nxt.cnt = w_cnt_nxt;
`endif
    end

    // BTB storage: cleared asynchronously, written once per resolved branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid  <= 1'b0;
                r_btb[i].tag    <= '0;
                r_btb[i].target <= '0;
`ifndef BP_GSHARE_EN
                r_btb[i].cnt    <= c_cnt_wnt;
`endif
            end
        end else if (w_btb_we) begin
            r_btb[w_upd_idx] <= w_btb_nxt;
        end
    end

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;
    logic [CNT_W-1:0] r_pht [ENTRIES];

    assign w_lk_cnt  = r_pht[w_lk_idx ^ r_ghr];
    assign w_upd_cnt = r_pht[w_upd_idx ^ r_ghr];

    // Pattern table follows BTB writes; history shifts on conditional resolutions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_pht[i] <= c_cnt_wnt;
            end
        end else begin
            if (w_btb_we) begin
                r_pht[w_upd_idx ^ r_ghr] <= w_cnt_nxt;
            end
            if (upd_valid_EX && upd_cond_EX) begin
                r_ghr <= {r_ghr[IDX_W-2:0], upd_taken_EX};
            end
        end
    end
`else
    assign w_lk_cnt  = w_lk_entry.cnt;
    assign w_upd_cnt = w_upd_entry.cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor with a table-level
//               reference model (also models BP_GSHARE_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    import bp_pkg::*;

    localparam int ENTRIES = 64;
    localparam int IDXW    = 6;
    localparam int TAGW    = 8;
    localparam int CNTMAX  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_IF;
    logic        pred_hit_IF, pred_taken_IF;
    logic [31:0] pred_target_IF;
    logic        upd_valid_EX, upd_cond_EX, upd_taken_EX, upd_pred_taken_EX;
    logic [31:0] upd_pc_EX, upd_target_EX, upd_pred_target_EX;
    logic        mispredict_EX;
    logic [31:0] redirect_pc_EX;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk                (clk),
        .rst                (rst),
        .pc_IF              (pc_IF),
        .pred_hit_IF        (pred_hit_IF),
        .pred_taken_IF      (pred_taken_IF),
        .pred_target_IF     (pred_target_IF),
        .upd_valid_EX       (upd_valid_EX),
        .upd_cond_EX        (upd_cond_EX),
        .upd_pc_EX          (upd_pc_EX),
        .upd_taken_EX       (upd_taken_EX),
        .upd_target_EX      (upd_target_EX),
        .upd_pred_taken_EX  (upd_pred_taken_EX),
        .upd_pred_target_EX (upd_pred_target_EX),
        .mispredict_EX      (mispredict_EX),
        .redirect_pc_EX     (redirect_pc_EX)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------- reference model
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int unsigned m_ghr;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_cnt[i]    = 1;
        end
        m_ghr = 0;
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAGW);
    endfunction

    function automatic int unsigned m_cidx(input int unsigned i);
`ifdef BP_GSHARE_EN
        return i ^ m_ghr;
`else
        return i;
`endif
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic hit,
                                         output logic tk, output logic [31:0] tgt);
        int unsigned i = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        tk  = hit && (m_cnt[m_cidx(i)] >= 2);
        tgt = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic cond, input logic [31:0] pc,
                                         input logic taken, input logic [31:0] tgt);
        int unsigned i  = m_idx(pc);
        int unsigned ci = m_cidx(i);
        if (m_valid[i] && (m_tag[i] == m_tagof(pc))) begin
            if (!cond)      m_cnt[ci] = CNTMAX;
            else if (taken) m_cnt[ci] = (m_cnt[ci] == CNTMAX) ? CNTMAX : m_cnt[ci] + 1;
            else            m_cnt[ci] = (m_cnt[ci] == 0) ? 0 : m_cnt[ci] - 1;
            if (!cond || taken) m_target[i] = tgt;
        end else if (taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tagof(pc);
            m_target[i] = tgt;
            m_cnt[ci]   = cond ? 2 : CNTMAX;
        end
        if (cond) m_ghr = ((m_ghr << 1) | int'(taken)) % ENTRIES;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic set_upd(input logic v, input logic cond, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        upd_valid_EX       = v;
        upd_cond_EX        = cond;
        upd_pc_EX          = pc;
        upd_taken_EX       = tk;
        upd_target_EX      = tgt;
        upd_pred_taken_EX  = ptk;
        upd_pred_target_EX = ptgt;
    endtask

    // Advance one edge, mirroring the edge into the model, then step off it
    task automatic tick();
        @(posedge clk);
        if (rst && upd_valid_EX)
            model_update(upd_cond_EX, upd_pc_EX, upd_taken_EX, upd_target_EX);
        #1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst   = 1'b0;
        pc_IF = 32'h100;
        set_upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        model_reset();
        #2;
        n_checks++;
        if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL reset_lookup: got hit=%0b taken=%0b tgt=%h want 0 0 00000104",
                     pred_hit_IF, pred_taken_IF, pred_target_IF);
        end
        n_checks++;
        if (mispredict_EX !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mispredict: got %0b want 0", mispredict_EX);
        end
        tick();
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_learn: got hit=%0b want 0", pred_hit_IF);
        end
        tick();
    endtask

    task automatic test_basic();
        logic eh, et;
        logic [31:0] eg;
        pc_IF = 32'h100;
        set_upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        model_lookup(pc_IF, eh, et, eg);
`ifndef BP_GSHARE_EN
        eh = 1'b1; et = 1'b1; eg = 32'h80;
`endif
        n_checks++;
        if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {eh, et, eg}) begin
            n_fail++;
            $display("FAIL basic_alloc: got hit=%0b taken=%0b tgt=%h want %0b %0b %h",
                     pred_hit_IF, pred_taken_IF, pred_target_IF, eh, et, eg);
        end
    endtask

    task automatic test_counter();
        logic [4:0] seq     = 5'b11000;  // taken bit per update, bit 0 first
        logic [4:0] exp_tk  = 5'b10000;  // prediction after each update
        logic eh, et;
        logic [31:0] eg;
        pc_IF = 32'h100;
        for (int k = 0; k < 5; k++) begin
            set_upd(1'b1, 1'b1, 32'h100, seq[k], 32'h80, 1'b0, 32'h0);
            tick();
            set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            model_lookup(pc_IF, eh, et, eg);
`ifndef BP_GSHARE_EN
            eh = 1'b1; et = exp_tk[k]; eg = et ? 32'h80 : 32'h104;
`endif
            n_checks++;
            if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {eh, et, eg}) begin
                n_fail++;
                $display("FAIL counter_step%0d: got hit=%0b taken=%0b tgt=%h want %0b %0b %h",
                         k, pred_hit_IF, pred_taken_IF, pred_target_IF, eh, et, eg);
            end
        end
    endtask

    task automatic test_alias();
        pc_IF = 32'h100;
        set_upd(1'b1, 1'b1, 32'h4100, 1'b0, 32'h300, 1'b0, 32'h0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_nt_keeps: got hit=%0b want 1", pred_hit_IF);
        end
        set_upd(1'b1, 1'b1, 32'h4100, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_evict: got hit=%0b want 0", pred_hit_IF);
        end
        pc_IF = 32'h4100;
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_new_hit: got hit=%0b want 1", pred_hit_IF);
        end
    endtask

    task automatic test_same_cycle();
        pc_IF = 32'h100;
        set_upd(1'b1, 1'b1, 32'h100, 1'b1, 32'h88, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old: got hit=%0b want 0", pred_hit_IF);
        end
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_hit_IF !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_new: got hit=%0b want 1", pred_hit_IF);
        end
    endtask

    task automatic test_mispredict();
        logic [31:0] pcs   [4] = '{32'h200, 32'hFFFF_FFFC, 32'h300, 32'h400};
        logic [31:0] tgts  [4] = '{32'h90, 32'h40, 32'h0, 32'h500};
        logic [31:0] ptgts [4] = '{32'h80, 32'h0, 32'h0, 32'h500};
        logic [3:0]  tks       = 4'b1001;
        logic [3:0]  ptks      = 4'b1101;
        logic [3:0]  emis      = 4'b0101;
        logic [31:0] eredir [4] = '{32'h90, 32'h0000_0000, 32'h304, 32'h500};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_upd(1'b1, 1'b1, pcs[k], tks[k], tgts[k], ptks[k], ptgts[k]);
            #1;
            n_checks++;
            if ({mispredict_EX, redirect_pc_EX} !== {emis[k], eredir[k]}) begin
                n_fail++;
                $display("FAIL mispredict_case%0d: got mis=%0b redir=%h want %0b %h",
                         k, mispredict_EX, redirect_pc_EX, emis[k], eredir[k]);
            end
            upd_valid_EX = 1'b0;
            #1;
            n_checks++;
            if (mispredict_EX !== 1'b0) begin
                n_fail++;
                $display("FAIL mispredict_idle%0d: got %0b want 0", k, mispredict_EX);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic eh, et, h2, ptk, cond, tk, emis;
        logic [31:0] eg, ptgt, upc, utgt, eredir;
        for (int n = 0; n < 600; n++) begin
            pc_IF = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 1)) << 8)
                  | (32'($urandom_range(0, 7)) << 2);
            upc   = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 1)) << 8)
                  | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 15) == 0) upc = 32'hFFFF_FFFC;
            cond  = ($urandom_range(0, 3) != 0);
            tk    = cond ? 1'($urandom_range(0, 1)) : 1'b1;
            utgt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                model_lookup(upc, h2, ptk, ptgt);
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = $urandom & 32'hFFFF_FFFC;
            end
            set_upd(1'($urandom_range(0, 3) != 0), cond, upc, tk, utgt, ptk, ptgt);
            #1;
            model_lookup(pc_IF, eh, et, eg);
            emis   = upd_valid_EX && ((ptk != tk) || (tk && (ptgt != utgt)));
            eredir = tk ? utgt : upc + 32'd4;
            n_checks++;
            if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {eh, et, eg}) begin
                n_fail++;
                $display("FAIL rand_lookup@%0d pc=%h: got %0b %0b %h want %0b %0b %h", n, pc_IF,
                         pred_hit_IF, pred_taken_IF, pred_target_IF, eh, et, eg);
            end
            n_checks++;
            if ({mispredict_EX, redirect_pc_EX} !== {emis, eredir}) begin
                n_fail++;
                $display("FAIL rand_resolve@%0d: got mis=%0b redir=%h want %0b %h",
                         n, mispredict_EX, redirect_pc_EX, emis, eredir);
            end
            tick();
        end
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_async_reset();
        pc_IF = 32'h100;
        set_upd(1'b1, 1'b0, 32'h100, 1'b1, 32'h700, 1'b0, 32'h0);
        tick();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {1'b1, 1'b1, 32'h700}) begin
            n_fail++;
            $display("FAIL areset_trained: got %0b %0b %h want 1 1 00000700",
                     pred_hit_IF, pred_taken_IF, pred_target_IF);
        end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({pred_hit_IF, pred_taken_IF, pred_target_IF} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL areset_immediate: got %0b %0b %h want 0 0 00000104",
                     pred_hit_IF, pred_taken_IF, pred_target_IF);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            pc_IF = (32'(k / 8) << 8) | (32'(k % 8) << 2);
            #1;
            n_checks++;
            if (pred_hit_IF !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_cleared pc=%h: got hit=%0b want 0", pc_IF, pred_hit_IF);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_counter();
        test_alias();
        test_same_cycle();
        test_mispredict();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: a direct-mapped branch target buffer (BTB) with saturating-counter direction prediction.
- Sits beside the PC/NPC logic in IF. The core redirects fetch in IF on a predicted-taken hit, instead of always waiting for EX resolution.
- EX reports each resolved branch/jump back to the block. The block updates its tables and flags the mispredict that drives the IF/ID and ID/EX flush.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB entries; power of two, at least 4. IDX_W = log2(ENTRIES).
- TAG_W, 8, stored tag bits; XLEN >= IDX_W+2+TAG_W.
- CNT_W, 2, direction counter width; at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_IF  in  XLEN  PC being fetched.
- pred_hit_IF  out  1  valid entry with a matching tag.
- pred_taken_IF  out  1  hit and counter MSB = 1.
- pred_target_IF  out  XLEN  stored target when pred_taken_IF, else pc_IF+4.
- upd_valid_EX  in  1  a branch/jump resolved in EX this cycle.
- upd_cond_EX  in  1  1 = conditional branch, 0 = JAL/JALR.
- upd_pc_EX  in  XLEN  PC of the resolved instruction.
- upd_taken_EX  in  1  actual direction.
- upd_target_EX  in  XLEN  actual target.
- upd_pred_taken_EX  in  1  prediction carried down the pipe.
- upd_pred_target_EX  in  XLEN  predicted target carried down the pipe.
- mispredict_EX  out  1  redirect required.
- redirect_pc_EX  out  XLEN  correct next PC.

Behaviour:
- Index: pc[IDX_W+1:2]. Tag: pc[IDX_W+TAG_W+1:IDX_W+2]. The same mapping applies to lookup and update.
- Lookup is combinational, zero latency, and reads pre-edge state. No write-to-read bypass: an update and a lookup to the same index in the same cycle return the old entry; the new entry is visible from the next cycle.
- Reset (rst=0, asynchronous): all valid bits = 0, all counters = weakly-not-taken (0b01 for CNT_W=2, i.e. 2^(CNT_W-1)-1), all targets/tags = 0, GHR = 0. Outputs while reset is asserted: pred_hit_IF=0, pred_taken_IF=0, pred_target_IF=pc_IF+4, mispredict_EX=0. Reset mid-operation discards all learned state immediately.
- mispredict_EX = upd_valid_EX && (upd_pred_taken_EX != upd_taken_EX || (upd_taken_EX && upd_pred_target_EX != upd_target_EX)).
- redirect_pc_EX = upd_taken_EX ? upd_target_EX : upd_pc_EX+4. Evaluated even when mispredict_EX=0.
- Update on the edge when upd_valid_EX=1:
  - Hit, conditional: counter saturating +1 if taken, -1 if not taken; clamps at 0 and 2^CNT_W-1. Target overwritten only if taken.
  - Hit, jump: counter forced to max; target overwritten.
  - Miss, taken: allocate and replace: valid=1, new tag, target. Counter = weakly-taken (2^(CNT_W-1)) for a conditional, max for a jump.
  - Miss, not taken: no change.
- All PC arithmetic is modulo 2^XLEN; pc+4 wraps silently.
- upd_valid_EX=0: no state change. Other upd_* inputs are don't-care.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR).
  - Direction counters move to a separate ENTRIES-deep pattern table indexed by pc index XOR GHR. The BTB still supplies hit and target.
  - GHR shifts left, inserting upd_taken_EX, on each conditional update only; it is updated at resolution (non-speculative).
  - Lookup and update both use the current GHR.
- Undefined: counters live in the BTB entry, there is no GHR, and behaviour is exactly as above.

Decomposition:
- Package bp_pkg:
  - counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST for CNT_W=2;
  - index/tag slicing functions;
  - BTB entry struct {valid, tag, target, cnt}.
- Sub-module bp_sat_counter: combinational next-counter function (cur, taken, force_max) -> next. It is instantiated for the update path.

Test Plan:
- After reset, lookup 0x100 -> hit=0, taken=0, target=0x104. Then update pc 0x100, cond, taken, target 0x80 -> next cycle lookup 0x100: hit=1, taken=1, target=0x80.
- Counter: two not-taken updates at 0x100 -> taken=0 (counter 00). Third not-taken stays 00. One taken -> 01, still not taken. Second taken -> 10, taken=1.
- Alias: 0x100 resident. Not-taken update at 0x4100 (same index, different tag) -> no allocation, 0x100 still hits. Taken update at 0x4100 -> 0x100 now misses.
- Same cycle: lookup 0x100 with update allocating 0x100 -> hit=0 that cycle, hit=1 next.
- Mispredict: upd pred_taken=1, target 0x80, actual taken, target 0x90 -> mispredict=1, redirect 0x90. Not taken at pc 0xFFFFFFFC -> redirect 0x00000000.
- Async reset: assert rst=0 between clock edges after training -> hit=0 immediately. Release rst -> no entries valid.
